// File: rtl/branch_rs.sv
// Branch reservation station: a compacting age-ordered queue of jal/jalr/branch
// uops that wake on CDB broadcasts and issue oldest-ready-first to the branch unit.
module branch_rs #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned ROB_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [31:0]            disp_pc,
  input  logic [31:0]            disp_pc_next,
  input  logic [6:0]             disp_opcode,
  input  logic [2:0]             disp_funct3,
  input  logic [31:0]            disp_imm,
  input  logic [ROB_W-1:0]       disp_rob_id,
  input  logic [TAG_W-1:0]       disp_rd_tag,
  input  logic                   disp_uses_rs1,
  input  logic                   disp_uses_rs2,
  input  logic                   disp_rs1_rdy,
  input  logic                   disp_rs2_rdy,
  input  logic [TAG_W-1:0]       disp_rs1_tag,
  input  logic [TAG_W-1:0]       disp_rs2_tag,
  input  logic [31:0]            disp_rs1_data,
  input  logic [31:0]            disp_rs2_data,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [31:0]            cdb_data,
  input  logic                   stall_br,
  output logic                   iss_valid,
  output logic [31:0]            iss_pc,
  output logic [31:0]            iss_pc_next,
  output logic [31:0]            iss_imm,
  output logic [31:0]            iss_rs1_data,
  output logic [31:0]            iss_rs2_data,
  output logic [6:0]             iss_opcode,
  output logic [2:0]             iss_funct3,
  output logic [ROB_W-1:0]       iss_rob_id,
  output logic [TAG_W-1:0]       iss_rd_tag,
  output logic                   iss_uses_rs1,
  output logic                   iss_uses_rs2,
  output logic                   iss_uses_imm,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [31:0]      imm;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [ROB_W-1:0] rob_id;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             rs1_rdy;
    logic             rs2_rdy;
  } entry_t;

  entry_t           ent_q  [DEPTH];
  entry_t           ent_d  [DEPTH];
  entry_t           ent_w  [DEPTH];
  entry_t           ent_sh [DEPTH];
  entry_t           disp_ent;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [DEPTH-1:0] rdy;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] wr_idx;
  logic             iss_fire;
  logic             accept;
  logic             byp1;
  logic             byp2;

  // Oldest ready entry, from registered state only (no CDB-to-issue bypass).
  always_comb begin
    rdy = '0;
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = (CNT_W'(i) < count_q) && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
      if (rdy[i]) sel = IDX_W'(i);
    end
  end

  assign iss_valid  = |rdy;
  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign iss_fire   = iss_valid && !stall_br;
  assign accept     = disp_valid && disp_ready;
  assign wr_idx     = count_q[IDX_W-1:0] - IDX_W'(iss_fire);
  assign count_d    = count_q + CNT_W'(accept) - CNT_W'(iss_fire);

  // CDB wakeup applied to every slot before compaction.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      if (cdb_valid && !ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_tag)) begin
        ent_w[i].rs1_rdy  = 1'b1;
        ent_w[i].rs1_data = cdb_data;
      end
      if (cdb_valid && !ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_tag)) begin
        ent_w[i].rs2_rdy  = 1'b1;
        ent_w[i].rs2_data = cdb_data;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_shift
    if (g == DEPTH - 1) begin : g_top
      assign ent_sh[g] = ent_w[g];
    end else begin : g_mid
      assign ent_sh[g] = (iss_fire && (IDX_W'(g) >= sel)) ? ent_w[g+1] : ent_w[g];
    end
  end

  // Incoming uop, with operands captured from a same-cycle broadcast.
  always_comb begin
    byp1              = cdb_valid && !disp_rs1_rdy && (disp_rs1_tag == cdb_tag);
    byp2              = cdb_valid && !disp_rs2_rdy && (disp_rs2_tag == cdb_tag);
    disp_ent.pc       = disp_pc;
    disp_ent.pc_next  = disp_pc_next;
    disp_ent.imm      = disp_imm;
    disp_ent.opcode   = disp_opcode;
    disp_ent.funct3   = disp_funct3;
    disp_ent.rob_id   = disp_rob_id;
    disp_ent.rd_tag   = disp_rd_tag;
    disp_ent.rs1_tag  = disp_rs1_tag;
    disp_ent.rs2_tag  = disp_rs2_tag;
    disp_ent.uses_rs1 = disp_uses_rs1;
    disp_ent.uses_rs2 = disp_uses_rs2;
    disp_ent.rs1_rdy  = !disp_uses_rs1 || disp_rs1_rdy || byp1;
    disp_ent.rs2_rdy  = !disp_uses_rs2 || disp_rs2_rdy || byp2;
    disp_ent.rs1_data = byp1 ? cdb_data : disp_rs1_data;
    disp_ent.rs2_data = byp2 ? cdb_data : disp_rs2_data;
  end

  always_comb begin
    ent_d = ent_sh;
    if (accept) ent_d[wr_idx] = disp_ent;
  end

  // Reset beats flush beats everything; slot payloads need no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
    ent_q <= ent_d;
  end

  assign count        = count_q;
  assign iss_pc       = ent_q[sel].pc;
  assign iss_pc_next  = ent_q[sel].pc_next;
  assign iss_imm      = ent_q[sel].imm;
  assign iss_rs1_data = ent_q[sel].rs1_data;
  assign iss_rs2_data = ent_q[sel].rs2_data;
  assign iss_opcode   = ent_q[sel].opcode;
  assign iss_funct3   = ent_q[sel].funct3;
  assign iss_rob_id   = ent_q[sel].rob_id;
  assign iss_rd_tag   = ent_q[sel].rd_tag;
  assign iss_uses_rs1 = ent_q[sel].uses_rs1;
  assign iss_uses_rs2 = ent_q[sel].uses_rs2;
  assign iss_uses_imm = 1'b1;

endmodule

// File: tb/tb_branch_rs.sv
// Bench for branch_rs: directed sequences, a vector table and randomized traffic
// checked every cycle against a queue-based reference model.
module tb_branch_rs;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned ROB_W = 4;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR   = 7'h63;

  logic clk, rst, flush, disp_valid, disp_ready;
  logic [31:0] disp_pc, disp_pc_next, disp_imm, disp_rs1_data, disp_rs2_data, cdb_data;
  logic [6:0] disp_opcode;
  logic [2:0] disp_funct3;
  logic [ROB_W-1:0] disp_rob_id;
  logic [TAG_W-1:0] disp_rd_tag, disp_rs1_tag, disp_rs2_tag, cdb_tag;
  logic disp_uses_rs1, disp_uses_rs2, disp_rs1_rdy, disp_rs2_rdy, cdb_valid, stall_br;
  logic iss_valid, iss_uses_rs1, iss_uses_rs2, iss_uses_imm;
  logic [31:0] iss_pc, iss_pc_next, iss_imm, iss_rs1_data, iss_rs2_data;
  logic [6:0] iss_opcode;
  logic [2:0] iss_funct3;
  logic [ROB_W-1:0] iss_rob_id;
  logic [TAG_W-1:0] iss_rd_tag;
  logic [2:0] count;

  branch_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_pc(disp_pc), .disp_pc_next(disp_pc_next), .disp_opcode(disp_opcode),
    .disp_funct3(disp_funct3), .disp_imm(disp_imm), .disp_rob_id(disp_rob_id),
    .disp_rd_tag(disp_rd_tag), .disp_uses_rs1(disp_uses_rs1), .disp_uses_rs2(disp_uses_rs2),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs1_tag(disp_rs1_tag),
    .disp_rs2_tag(disp_rs2_tag), .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .stall_br(stall_br),
    .iss_valid(iss_valid), .iss_pc(iss_pc), .iss_pc_next(iss_pc_next), .iss_imm(iss_imm),
    .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data), .iss_opcode(iss_opcode),
    .iss_funct3(iss_funct3), .iss_rob_id(iss_rob_id), .iss_rd_tag(iss_rd_tag),
    .iss_uses_rs1(iss_uses_rs1), .iss_uses_rs2(iss_uses_rs2), .iss_uses_imm(iss_uses_imm),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit model_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: age-ordered queue, oldest at index 0.
  typedef struct {
    logic [31:0] pc, pcn, imm, d1, d2;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [ROB_W-1:0] rob;
    logic [TAG_W-1:0] rd, t1, t2;
    logic u1, u2, r1, r2;
  } ment_t;
  ment_t mq[$];

  function automatic bit m_ready(input ment_t e);
    return (!e.u1 || e.r1) && (!e.u2 || e.r2);
  endfunction

  function automatic int m_first();
    for (int i = 0; i < mq.size(); i++) if (m_ready(mq[i])) return i;
    return -1;
  endfunction

  task automatic model_check();
    int k;
    k = m_first();
    chk("m_iss_valid", 32'(iss_valid), 32'(k >= 0));
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
    if (k >= 0) begin
      chk("m_pc", iss_pc, mq[k].pc);
      chk("m_pc_next", iss_pc_next, mq[k].pcn);
      chk("m_imm", iss_imm, mq[k].imm);
      chk("m_opcode", 32'(iss_opcode), 32'(mq[k].op));
      chk("m_funct3", 32'(iss_funct3), 32'(mq[k].f3));
      chk("m_rob_id", 32'(iss_rob_id), 32'(mq[k].rob));
      chk("m_rd_tag", 32'(iss_rd_tag), 32'(mq[k].rd));
      chk("m_uses_rs1", 32'(iss_uses_rs1), 32'(mq[k].u1));
      chk("m_uses_rs2", 32'(iss_uses_rs2), 32'(mq[k].u2));
      chk("m_uses_imm", 32'(iss_uses_imm), 32'd1);
      if (mq[k].u1) chk("m_rs1_data", iss_rs1_data, mq[k].d1);
      if (mq[k].u2) chk("m_rs2_data", iss_rs2_data, mq[k].d2);
    end
  endtask

  task automatic model_step();
    int k;
    bit acc;
    ment_t e;
    if (!rst || flush) begin
      mq.delete();
      return;
    end
    acc = disp_valid && (mq.size() < DEPTH);
    k = m_first();
    if (k >= 0 && !stall_br) mq.delete(k);
    foreach (mq[i]) begin
      e = mq[i];
      if (cdb_valid && e.u1 && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.d1 = cdb_data; end
      if (cdb_valid && e.u2 && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.d2 = cdb_data; end
      mq[i] = e;
    end
    if (acc) begin
      e.pc = disp_pc; e.pcn = disp_pc_next; e.imm = disp_imm; e.op = disp_opcode;
      e.f3 = disp_funct3; e.rob = disp_rob_id; e.rd = disp_rd_tag;
      e.u1 = disp_uses_rs1; e.u2 = disp_uses_rs2; e.t1 = disp_rs1_tag; e.t2 = disp_rs2_tag;
      e.r1 = disp_rs1_rdy; e.r2 = disp_rs2_rdy; e.d1 = disp_rs1_data; e.d2 = disp_rs2_data;
      if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.d1 = cdb_data; end
      if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.d2 = cdb_data; end
      mq.push_back(e);
    end
  endtask

  // Inputs change at posedge+1; model compared at negedge and advanced at posedge.
  task automatic cycle();
    @(negedge clk);
    if (model_on) model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_disp(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                            input logic u1, input logic r1, input logic [TAG_W-1:0] t1,
                            input logic [31:0] d1, input logic u2, input logic r2,
                            input logic [TAG_W-1:0] t2, input logic [31:0] d2);
    disp_valid = 1'b1; disp_opcode = op; disp_pc = pc; disp_pc_next = pc + 32'd4;
    disp_imm = imm; disp_funct3 = 3'd0; disp_rob_id = ROB_W'(pc[5:2]); disp_rd_tag = 6'd1;
    disp_uses_rs1 = u1; disp_rs1_rdy = r1; disp_rs1_tag = t1; disp_rs1_data = d1;
    disp_uses_rs2 = u2; disp_rs2_rdy = r2; disp_rs2_tag = t2; disp_rs2_data = d2;
  endtask

  task automatic idle_in();
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  typedef struct {
    logic [6:0] op; logic [31:0] pc, imm;
    logic u1, r1; logic [TAG_W-1:0] t1; logic [31:0] d1;
    logic u2, r2; logic [TAG_W-1:0] t2; logic [31:0] d2;
    logic cv; logic [TAG_W-1:0] ct; logic [31:0] cd;
    logic ev; logic [31:0] e1, e2;
  } vec_t;
  vec_t vt[7];

  logic [31:0] held_pc;

  initial begin
    vt[0] = '{op:OP_JAL, pc:32'h2000, imm:32'h40, u1:0, r1:0, t1:6'd0, d1:0, u2:0, r2:0, t2:6'd0, d2:0,
              cv:0, ct:6'd0, cd:0, ev:1, e1:0, e2:0};
    vt[1] = '{op:OP_JALR, pc:32'h2004, imm:32'h8, u1:1, r1:1, t1:6'd2, d1:32'h1234, u2:0, r2:0, t2:6'd0, d2:0,
              cv:0, ct:6'd0, cd:0, ev:1, e1:32'h1234, e2:0};
    vt[2] = '{op:OP_BR, pc:32'h2008, imm:32'hFFFFFFF0, u1:1, r1:0, t1:6'd4, d1:32'hDEAD, u2:1, r2:0, t2:6'd4, d2:32'hDEAD,
              cv:1, ct:6'd4, cd:32'hBEEF, ev:1, e1:32'hBEEF, e2:32'hBEEF};
    vt[3] = '{op:OP_BR, pc:32'h200C, imm:32'h10, u1:1, r1:1, t1:6'd0, d1:32'h11, u2:1, r2:0, t2:6'd8, d2:0,
              cv:1, ct:6'd9, cd:32'h22, ev:0, e1:0, e2:0};
    vt[4] = '{op:OP_BR, pc:32'h2010, imm:32'h14, u1:1, r1:1, t1:6'd0, d1:32'h55, u2:0, r2:0, t2:6'd2, d2:0,
              cv:0, ct:6'd0, cd:0, ev:1, e1:32'h55, e2:0};
    vt[5] = '{op:OP_BR, pc:32'h2014, imm:32'h18, u1:1, r1:0, t1:6'd10, d1:0, u2:1, r2:1, t2:6'd0, d2:32'h66,
              cv:0, ct:6'd10, cd:32'h77, ev:0, e1:0, e2:0};
    vt[6] = '{op:OP_BR, pc:32'h2018, imm:32'h1C, u1:1, r1:1, t1:6'd3, d1:32'h99, u2:0, r2:0, t2:6'd0, d2:0,
              cv:1, ct:6'd3, cd:32'hAB, ev:1, e1:32'h99, e2:0};

    rst = 1'b0; stall_br = 1'b0; cdb_tag = '0; cdb_data = '0;
    idle_in();
    drive_disp(OP_JAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    disp_valid = 1'b0;
    cycle(); cycle();
    rst = 1'b1; model_on = 1'b1;
    cycle();
    chk("reset_iss_valid", 32'(iss_valid), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_disp_ready", 32'(disp_ready), 32'd1);

    // jal with no sources issues the cycle after dispatch
    drive_disp(OP_JAL, 32'h1000, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("jal_not_before", 32'(iss_valid), 32'd0);
    cycle(); idle_in();
    chk("jal_valid", 32'(iss_valid), 32'd1);
    chk("jal_pc", iss_pc, 32'h1000);
    chk("jal_imm", iss_imm, 32'h20);
    chk("jal_count1", 32'(count), 32'd1);
    cycle();
    chk("jal_count0", 32'(count), 32'd0);
    chk("jal_gone", 32'(iss_valid), 32'd0);

    // beq waiting on tag 5, woken by the CDB
    drive_disp(OP_BR, 32'h1100, 32'h8, 1, 0, 6'd5, 32'h0, 1, 1, 6'd6, 32'd7);
    cycle(); idle_in();
    chk("beq_wait0", 32'(iss_valid), 32'd0);
    cycle();
    chk("beq_wait1", 32'(iss_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'd7;
    cycle(); idle_in();
    chk("beq_valid", 32'(iss_valid), 32'd1);
    chk("beq_rs1", iss_rs1_data, 32'd7);
    chk("beq_rs2", iss_rs2_data, 32'd7);
    cycle();
    chk("beq_count0", 32'(count), 32'd0);

    // fill: A blocked on tag 3, then B,C,D ready
    stall_br = 1'b1;
    drive_disp(OP_BR, 32'hA0, 0, 1, 0, 6'd3, 0, 0, 0, 0, 0); cycle();
    drive_disp(OP_BR, 32'hB0, 0, 1, 1, 6'd0, 32'hB, 0, 0, 0, 0); cycle();
    drive_disp(OP_BR, 32'hC0, 0, 1, 1, 6'd0, 32'hC, 0, 0, 0, 0); cycle();
    drive_disp(OP_BR, 32'hD0, 0, 1, 1, 6'd0, 32'hD, 0, 0, 0, 0); cycle();
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_not_ready", 32'(disp_ready), 32'd0);
    chk("fill_sel_b", iss_pc, 32'hB0);
    drive_disp(OP_JAL, 32'hE0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(); idle_in();
    chk("full_ignores", 32'(count), 32'd4);
    stall_br = 1'b0;
    cycle();
    chk("order_c", iss_pc, 32'hC0);
    chk("order_c_cnt", 32'(count), 32'd3);
    cycle();
    chk("order_d", iss_pc, 32'hD0);
    cycle();
    chk("order_a_blocked", 32'(iss_valid), 32'd0);
    chk("order_a_cnt", 32'(count), 32'd1);
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h33;
    cycle(); idle_in();
    chk("order_a", iss_pc, 32'hA0);
    chk("order_a_rs1", iss_rs1_data, 32'h33);
    cycle();
    chk("order_empty", 32'(count), 32'd0);

    // stall holds a ready entry
    stall_br = 1'b1;
    drive_disp(OP_JALR, 32'h3000, 32'h4, 1, 1, 6'd0, 32'h77, 0, 0, 0, 0);
    cycle(); idle_in();
    held_pc = iss_pc;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_valid", 32'(iss_valid), 32'd1);
      chk("stall_pc", iss_pc, held_pc);
      chk("stall_count", 32'(count), 32'd1);
    end
    stall_br = 1'b0;
    cycle();
    chk("stall_release", 32'(count), 32'd0);

    // flush, then reset, against simultaneous dispatch/issue/CDB
    for (int pass = 0; pass < 2; pass++) begin
      stall_br = 1'b1;
      drive_disp(OP_BR, 32'h40, 0, 1, 1, 6'd0, 1, 0, 0, 0, 0); cycle();
      drive_disp(OP_BR, 32'h44, 0, 1, 0, 6'd9, 0, 0, 0, 0, 0); cycle();
      drive_disp(OP_BR, 32'h48, 0, 1, 1, 6'd0, 2, 0, 0, 0, 0); cycle();
      chk("kill_count3", 32'(count), 32'd3);
      drive_disp(OP_JAL, 32'h4C, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      stall_br = 1'b0; cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h9;
      if (pass == 0) flush = 1'b1; else rst = 1'b0;
      cycle(); idle_in(); rst = 1'b1;
      chk("kill_count0", 32'(count), 32'd0);
      chk("kill_iss_valid", 32'(iss_valid), 32'd0);
      chk("kill_disp_ready", 32'(disp_ready), 32'd1);
      cycle();
      chk("kill_no_late", 32'(iss_valid), 32'd0);
    end

    // vector table: single uop from empty, held by stall
    stall_br = 1'b1;
    foreach (vt[v]) begin
      flush = 1'b1; cycle(); flush = 1'b0;
      drive_disp(vt[v].op, vt[v].pc, vt[v].imm, vt[v].u1, vt[v].r1, vt[v].t1, vt[v].d1,
                 vt[v].u2, vt[v].r2, vt[v].t2, vt[v].d2);
      cdb_valid = vt[v].cv; cdb_tag = vt[v].ct; cdb_data = vt[v].cd;
      cycle(); idle_in();
      chk($sformatf("vec%0d_valid", v), 32'(iss_valid), 32'(vt[v].ev));
      if (vt[v].ev) begin
        chk($sformatf("vec%0d_pc", v), iss_pc, vt[v].pc);
        chk($sformatf("vec%0d_imm", v), iss_imm, vt[v].imm);
        if (vt[v].u1) chk($sformatf("vec%0d_rs1", v), iss_rs1_data, vt[v].e1);
        if (vt[v].u2) chk($sformatf("vec%0d_rs2", v), iss_rs2_data, vt[v].e2);
      end
    end
    stall_br = 1'b0;
    flush = 1'b1; cycle(); flush = 1'b0;

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 39) == 0);
      stall_br = ($urandom_range(0, 3) == 0);
      disp_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: disp_opcode = OP_JAL;
        1: disp_opcode = OP_JALR;
        default: disp_opcode = OP_BR;
      endcase
      disp_pc = 32'($urandom); disp_pc_next = 32'($urandom); disp_imm = 32'($urandom);
      disp_funct3 = 3'($urandom); disp_rob_id = ROB_W'($urandom); disp_rd_tag = TAG_W'($urandom);
      disp_uses_rs1 = 1'($urandom_range(0, 1)); disp_uses_rs2 = 1'($urandom_range(0, 1));
      disp_rs1_rdy = ($urandom_range(0, 2) == 0); disp_rs2_rdy = ($urandom_range(0, 2) == 0);
      disp_rs1_tag = TAG_W'($urandom_range(1, 6)); disp_rs2_tag = TAG_W'($urandom_range(1, 6));
      disp_rs1_data = 32'($urandom); disp_rs2_data = 32'($urandom);
      cdb_valid = ($urandom_range(0, 2) != 0);
      cdb_tag = TAG_W'($urandom_range(1, 6)); cdb_data = 32'($urandom);
      cycle();
    end
    idle_in(); rst = 1'b1; stall_br = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
